// File: rtl/murax_gpio_panel_pkg.sv
// Shared encodings for the Murax gpioA button/LED panel: GPIO bit map,
// LED modes, debounce states and the per-LED lit decision.
package murax_gpio_panel_pkg;

   localparam int NUM_LEDS = 2;

   typedef enum logic [1:0] {
      LED_OFF   = 2'b00,
      LED_ON    = 2'b01,
      LED_PWM   = 2'b10,
      LED_BLINK = 2'b11
   } led_mode_e;

   localparam int RED_MODE_LSB = 0;
   localparam int GRN_MODE_LSB = 2;
   localparam int ACK_BIT      = 7;
   localparam int RED_DUTY_LSB = 16;
   localparam int GRN_DUTY_LSB = 24;

   localparam int RD_PRESSED = 0;
   localparam int RD_EVT     = 1;
   localparam int RD_RAW     = 2;
   localparam int RD_CNT_LSB = 8;

   typedef enum logic [1:0] {
      DB_RELEASED,
      DB_WAIT_PRESS,
      DB_PRESSED,
      DB_WAIT_RELEASE
   } db_state_e;

   function automatic logic led_lit(logic [1:0] mode, logic [7:0] pwm_cnt,
                                    logic [7:0] duty, logic phase);
      logic lit;
      lit = 1'b0;
      case (mode)
         LED_ON:    lit = 1'b1;
         LED_PWM:   lit = pwm_cnt < duty;
         LED_BLINK: lit = phase;
         default:   lit = 1'b0;
      endcase
      return lit;
   endfunction

endpackage

// File: rtl/murax_btn_debounce.sv
// Two-flop synchroniser plus a four-state debounce FSM; press_evt marks the
// cycle in which a press finishes qualifying.
module murax_btn_debounce
   import murax_gpio_panel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 120000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic synced,
   output logic pressed,
   output logic press_evt
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic [1:0]    sync_q;
   db_state_e     state;
   logic [CW-1:0] cnt;
   logic          last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], btn_n};
   end

   assign synced = sync_q[1];
   assign last   = cnt == CW'(DEBOUNCE_CYCLES - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= DB_RELEASED;
         cnt   <= '0;
      end else begin
         case (state)
            DB_RELEASED:
               if (!synced) begin
                  state <= DB_WAIT_PRESS;
                  cnt   <= CW'(1);
               end
            DB_WAIT_PRESS:
               if (synced) begin
                  state <= DB_RELEASED;
                  cnt   <= '0;
               end else if (last) begin
                  state <= DB_PRESSED;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            DB_PRESSED:
               if (synced) begin
                  state <= DB_WAIT_RELEASE;
                  cnt   <= CW'(1);
               end
            DB_WAIT_RELEASE:
               if (!synced) begin
                  state <= DB_PRESSED;
                  cnt   <= '0;
               end else if (last) begin
                  state <= DB_RELEASED;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            default: begin
               state <= DB_RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign pressed   = (state == DB_PRESSED) || (state == DB_WAIT_RELEASE);
   // Decoded from the qualifying transition so the flag and count land on
   // the same edge as pressed.
   assign press_evt = (state == DB_WAIT_PRESS) && !synced && last;

endmodule

// File: rtl/murax_gpio_panel_ctrl.sv
// gpioA-facing panel controller: button event flag/count on the read port,
// per-LED off/on/PWM/blink modes decoded from the write port.
module murax_gpio_panel_ctrl
   import murax_gpio_panel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int PWM_PRESCALE    = 47,
   parameter int BLINK_CYCLES    = 3000000,
   parameter bit LED_ACTIVE_LOW  = 1'b1
) (
   input  logic        io_mainClk,
   input  logic        io_asyncReset,
   input  logic [31:0] io_gpio_write,
   input  logic [31:0] io_gpio_writeEnable,
   output logic [31:0] io_gpio_read,
   input  logic        io_btn_n,
   output logic        io_led_r,
   output logic        io_led_g
);
   localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

   logic [31:0] w;
   logic        synced, pressed, press_evt;
   logic        evt_flag, ack_q, ack_rise;
   logic [7:0]  press_cnt;
   logic [PW-1:0] pre_cnt;
   logic [7:0]  pwm_cnt;
   logic [BW-1:0] blink_cnt;
   logic        blink_phase;
   logic        unused_w_bits;

   logic [NUM_LEDS-1:0][1:0] led_mode;
   logic [NUM_LEDS-1:0][7:0] led_duty;
   logic [NUM_LEDS-1:0]      led_pin;

   assign w             = io_gpio_write & io_gpio_writeEnable;
   assign ack_rise      = w[ACK_BIT] & ~ack_q;
   assign unused_w_bits = ^{w[15:8], w[6:4]};

   murax_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk       (io_mainClk),
      .rst       (io_asyncReset),
      .btn_n     (io_btn_n),
      .synced    (synced),
      .pressed   (pressed),
      .press_evt (press_evt)
   );

   // A new press outranks an ack edge in the same cycle so no event is lost.
   always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
      if (io_asyncReset) begin
         evt_flag  <= 1'b0;
         ack_q     <= 1'b0;
         press_cnt <= '0;
      end else begin
         ack_q <= w[ACK_BIT];
         if (press_evt) begin
            evt_flag  <= 1'b1;
            press_cnt <= press_cnt + 8'd1;
         end else if (ack_rise) begin
            evt_flag <= 1'b0;
         end
      end
   end

   always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
      if (io_asyncReset) begin
         pre_cnt     <= '0;
         pwm_cnt     <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         if (pre_cnt == PW'(PWM_PRESCALE - 1)) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
         end else begin
            pre_cnt <= pre_cnt + PW'(1);
         end
         if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   assign led_mode = {w[GRN_MODE_LSB +: 2], w[RED_MODE_LSB +: 2]};
   assign led_duty = {w[GRN_DUTY_LSB +: 8], w[RED_DUTY_LSB +: 8]};

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
      logic pin_q;
      always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
         if (io_asyncReset) pin_q <= LED_ACTIVE_LOW;
         else pin_q <= led_lit(led_mode[i], pwm_cnt, led_duty[i], blink_phase) ^ LED_ACTIVE_LOW;
      end
      assign led_pin[i] = pin_q;
   end

   assign io_led_r = led_pin[0];
   assign io_led_g = led_pin[1];

   always_comb begin
      io_gpio_read                      = '0;
      io_gpio_read[RD_PRESSED]          = pressed;
      io_gpio_read[RD_EVT]              = evt_flag;
      io_gpio_read[RD_RAW]              = synced;
      io_gpio_read[RD_CNT_LSB +: 8]     = press_cnt;
   end

endmodule

// File: tb/tb_murax_gpio_panel_ctrl.sv
// Randomized bench for murax_gpio_panel_ctrl against a run-length / cycle-count
// reference model, plus directed checks on the latency and boundary cases.
module tb_murax_gpio_panel_ctrl;
   localparam int D = 4;
   localparam int P = 1;
   localparam int B = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] gw  = '0;
   logic [31:0] gwe = '0;
   logic        btn = 1'b1;
   logic [31:0] rd;
   logic        led_r, led_g;

   int n_assert = 0;
   int n_fail   = 0;

   murax_gpio_panel_ctrl #(
      .DEBOUNCE_CYCLES(D), .PWM_PRESCALE(P), .BLINK_CYCLES(B), .LED_ACTIVE_LOW(1'b1)
   ) dut (
      .io_mainClk          (clk),
      .io_asyncReset       (rst),
      .io_gpio_write       (gw),
      .io_gpio_writeEnable (gwe),
      .io_gpio_read        (rd),
      .io_btn_n            (btn),
      .io_led_r            (led_r),
      .io_led_g            (led_g)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the synced level is the pin delayed two edges; a level
   // is accepted once it has differed from the accepted level for D edges.
   bit [1:0] m_dly;
   bit       m_level, m_flag, m_ack_prev, m_led_r, m_led_g, m_s, m_evt;
   int       m_run, m_presses, m_cyc;
   bit [31:0] m_w;

   function automatic bit lit(bit [1:0] mode, int n, bit [7:0] duty);
      case (mode)
         2'd0:    return 1'b0;
         2'd1:    return 1'b1;
         2'd2:    return ((n / P) % 256) < int'(duty);
         default: return ((n / B) % 2) == 1;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_dly = 2'b11; m_level = 1'b1; m_flag = 1'b0; m_ack_prev = 1'b0;
         m_led_r = 1'b1; m_led_g = 1'b1; m_run = 0; m_presses = 0; m_cyc = 0;
      end else begin
         m_w   = gw & gwe;
         m_s   = m_dly[1];
         m_evt = 1'b0;
         if (m_s != m_level) begin
            m_run++;
            if (m_run == D) begin
               m_level = m_s;
               m_run   = 0;
               m_evt   = (m_s == 1'b0);
            end
         end else begin
            m_run = 0;
         end
         if (m_evt) begin
            m_flag = 1'b1;
            m_presses++;
         end else if (m_w[7] && !m_ack_prev) begin
            m_flag = 1'b0;
         end
         m_ack_prev = m_w[7];
         m_led_r = !lit(m_w[1:0], m_cyc, m_w[23:16]);
         m_led_g = !lit(m_w[3:2], m_cyc, m_w[31:24]);
         m_dly   = {m_dly[0], btn};
         m_cyc++;
      end
   end

   function automatic logic [31:0] exp_read();
      logic [31:0] r;
      r       = '0;
      r[0]    = ~m_level;
      r[1]    = m_flag;
      r[2]    = m_dly[1];
      r[15:8] = m_presses[7:0];
      return r;
   endfunction

   always @(negedge clk) begin
      chk("model_read", rd, exp_read());
      chk("model_led_r", {31'b0, led_r}, {31'b0, m_led_r});
      chk("model_led_g", {31'b0, led_g}, {31'b0, m_led_g});
   end

   task automatic wait_cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_release(int lo, int hi);
      btn = 1'b0; wait_cyc(lo);
      btn = 1'b1; wait_cyc(hi);
   endtask

   task automatic ack_pulse();
      gw = 32'h80; gwe = 32'h80; wait_cyc(1);
      gw = '0; gwe = '0;
   endtask

   task automatic measure_lit(int n, output int lr, output int lg);
      lr = 0; lg = 0;
      repeat (n) begin
         @(negedge clk);
         if (!led_r) lr++;
         if (!led_g) lg++;
      end
   endtask

   initial begin
      int npress, lr, lg, toggles, found;
      bit prev_g;
      bit [7:0] dr, dg;
      npress = 0;

      wait_cyc(3);
      chk("reset_read", rd, 32'h4);
      chk("reset_led_r", {31'b0, led_r}, 32'h1);
      chk("reset_led_g", {31'b0, led_g}, 32'h1);

      // press and hold: qualification latency
      rst = 1'b0; btn = 1'b0;
      wait_cyc(2);
      chk("raw_sync_low", {31'b0, rd[2]}, 32'h0);
      wait_cyc(3);
      chk("not_yet_pressed", {30'b0, rd[1:0]}, 32'h0);
      wait_cyc(1);
      npress++;
      chk("pressed_evt", {30'b0, rd[1:0]}, 32'h3);
      chk("count_first", {24'b0, rd[15:8]}, npress);
      btn = 1'b1; wait_cyc(D + 4);
      chk("released", {31'b0, rd[0]}, 32'h0);
      ack_pulse();
      chk("ack_clears", {31'b0, rd[1]}, 32'h0);

      // bounce shorter than D never qualifies
      repeat (5) press_release($urandom_range(1, D - 1), $urandom_range(1, 3));
      wait_cyc(D + 3);
      chk("bounce_pressed", {30'b0, rd[1:0]}, 32'h0);
      chk("bounce_count", {24'b0, rd[15:8]}, npress);
      btn = 1'b0; wait_cyc(D + 6);
      npress++;
      chk("bounce_then_press", {24'b0, rd[15:8]}, npress);
      btn = 1'b1; wait_cyc(D + 4);
      ack_pulse(); wait_cyc(1);

      // ack rising edge coinciding with press_evt: set wins
      btn = 1'b0; wait_cyc(D + 1);
      gw = 32'h80; gwe = 32'h80; wait_cyc(1);
      npress++;
      chk("coincident_flag", {31'b0, rd[1]}, 32'h1);
      chk("coincident_count", {24'b0, rd[15:8]}, npress);
      btn = 1'b1; gw = '0; wait_cyc(D + 4);

      // ack held high must not clear a later event
      gw = 32'h80; wait_cyc(2);
      chk("held_ack_clear", {31'b0, rd[1]}, 32'h0);
      press_release(D + 3, D + 3);
      npress++;
      chk("held_ack_evt", {31'b0, rd[1]}, 32'h1);
      gw = '0; gwe = '0; wait_cyc(1);

      // 256 presses wrap the count back to its starting value
      for (int i = 0; i < 256; i++)
         press_release(D + 2 + $urandom_range(0, 2), D + 2 + $urandom_range(0, 2));
      chk("count_wrap", {24'b0, rd[15:8]}, npress % 256);
      chk("flag_after_wrap", {31'b0, rd[1]}, 32'h1);
      ack_pulse(); wait_cyc(1);

      // PWM duty boundaries and random duties on both LEDs
      gwe = 32'hFFFF_000F;
      gw  = {8'h00, 8'h40, 16'h0002}; wait_cyc(2);
      measure_lit(256, lr, lg);
      chk("pwm_40", lr, 64);
      gw  = {8'h00, 8'h00, 16'h0002}; wait_cyc(2);
      measure_lit(256, lr, lg);
      chk("pwm_00", lr, 0);
      gw  = {8'hFF, 8'hFF, 16'h000A}; wait_cyc(2);
      measure_lit(256, lr, lg);
      chk("pwm_ff_r", lr, 255);
      chk("pwm_ff_g", lg, 255);
      repeat (3) begin
         dr = 8'($urandom); dg = 8'($urandom);
         gw = {dg, dr, 16'h000A}; wait_cyc(2);
         measure_lit(256, lr, lg);
         chk("pwm_rand_r", lr, int'(dr));
         chk("pwm_rand_g", lg, int'(dg));
      end

      // blink: 64 intervals hold exactly 8 toggles
      gw = 32'h0000_000C; gwe = 32'h0000_000F; wait_cyc(2);
      toggles = 0; prev_g = led_g;
      repeat (64) begin
         @(negedge clk);
         if (led_g != prev_g) toggles++;
         prev_g = led_g;
      end
      chk("blink_toggles", toggles, 8);
      gwe = 32'h0000_0003; wait_cyc(1);
      chk("green_gated_off", {31'b0, led_g}, 32'h1);

      // reset asserted mid-blink while both LEDs lit
      gw = 32'h0000_000D; gwe = 32'h0000_000F;
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         @(negedge clk);
         if (!led_g) found = 1;
      end
      chk("blink_lit_seen", found, 1);
      chk("red_on_lit", {31'b0, led_r}, 32'h0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_led_r", {31'b0, led_r}, 32'h1);
      chk("async_rst_led_g", {31'b0, led_g}, 32'h1);
      chk("async_rst_read", rd, 32'h4);
      @(negedge clk);
      rst = 1'b0; gw = '0; gwe = '0;

      // held button must re-qualify fully after reset
      btn = 1'b0; wait_cyc(D + 1);
      chk("requal_wait", {31'b0, rd[0]}, 32'h0);
      wait_cyc(1);
      chk("requal_count", {24'b0, rd[15:8]}, 32'h1);
      btn = 1'b1; wait_cyc(D + 4);

      // random traffic, checked continuously against the model
      for (int i = 0; i < 1500; i++) begin
         gw  = $urandom;
         gwe = ($urandom_range(0, 3) == 0) ? $urandom : gwe;
         if ($urandom_range(0, 5) == 0) btn = ~btn;
         wait_cyc(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
